// File: rtl/truth_table_scanner.sv
// Truth-table scanner: sweeps all 2**N input codes through an external function, captures
// the table and count, then streams the set indices. Define MAXTERM_EN to add the mode port.
module truth_table_scanner #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              f_in,
`ifdef MAXTERM_EN
    input  logic              mode,
`endif
    output logic [N-1:0]      x_out,
    output logic              busy,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N-1:0]      m_index,
    output logic              m_last,
    output logic              done,
    output logic [(1<<N)-1:0] table_out,
    output logic [N:0]        count_out
);

    localparam int TW = 1 << N;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    x_q, x_d;
    logic [N-1:0]    p_q, p_d;
    logic [TW-1:0]   table_q, table_d;
    logic [N:0]      count_q, count_d;
    logic            busy_q, busy_d;

    logic [TW-1:0]   tgt_vec;
    logic [TW-1:0]   rest;
    logic            hit;
    logic            cur_bit;
    logic            last_hit;

`ifdef MAXTERM_EN
    logic            mode_q, mode_d;

    // In maxterm mode the emit/count logic looks for zeros, so invert the target view.
    assign tgt_vec = table_q ^ {TW{mode_q}};
    assign hit     = f_in ^ mode_q;
`else
    assign tgt_vec = table_q;
    assign hit     = f_in;
`endif

    assign cur_bit  = tgt_vec[p_q];
    assign rest     = tgt_vec >> p_q;
    assign last_hit = ((rest >> 1) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            p_q     <= '0;
            table_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
`ifdef MAXTERM_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            p_q     <= p_d;
            table_q <= table_d;
            count_q <= count_d;
            busy_q  <= busy_d;
`ifdef MAXTERM_EN
            mode_q  <= mode_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        p_d     = p_q;
        table_d = table_q;
        count_d = count_q;
        busy_d  = busy_q;
`ifdef MAXTERM_EN
        mode_d  = mode_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    x_d     = '0;
                    p_d     = '0;
                    table_d = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
`ifdef MAXTERM_EN
                    mode_d  = mode;
`endif
                end
            end
            S_SCAN: begin
                table_d[x_q] = f_in;
                count_d      = count_q + {{N{1'b0}}, hit};
                x_d          = x_q + 1'b1;
                if (x_q == '1) begin
                    state_d = S_EMIT;
                    p_d     = '0;
                end
            end
            S_EMIT: begin
                // Zero slots advance freely; a set slot waits for the handshake.
                if (!cur_bit || m_ready) begin
                    if (p_q == '1 || (cur_bit && last_hit)) begin
                        state_d = S_FIN;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                p_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign x_out     = x_q;
    assign busy      = busy_q;
    assign m_valid   = (state_q == S_EMIT) && cur_bit;
    assign m_index   = p_q;
    assign m_last    = m_valid && last_hit;
    assign done      = (state_q == S_FIN);
    assign table_out = table_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomised self-checking bench for truth_table_scanner (N=3) against a queue-based
// model of the expected index stream, table, count and completion timing.
module tb_truth_table_scanner;

    localparam int N  = 3;
    localparam int TW = 1 << N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          f_in;
`ifdef MAXTERM_EN
    logic          mode;
`endif
    logic [N-1:0]  x_out;
    logic          busy;
    logic          m_valid;
    logic          m_ready;
    logic [N-1:0]  m_index;
    logic          m_last;
    logic          done;
    logic [TW-1:0] table_out;
    logic [N:0]    count_out;

    logic [TW-1:0] func;

    int n_chk = 0;
    int n_err = 0;

    truth_table_scanner #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .f_in      (f_in),
`ifdef MAXTERM_EN
        .mode      (mode),
`endif
        .x_out     (x_out),
        .busy      (busy),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_index   (m_index),
        .m_last    (m_last),
        .done      (done),
        .table_out (table_out),
        .count_out (count_out)
    );

    // Function under scan: a lookup table indexed by the scanner's input vector.
    assign f_in = func[x_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_zero(input string pfx);
        chk({pfx, "_busy"},    int'(busy), 0);
        chk({pfx, "_m_valid"}, int'(m_valid), 0);
        chk({pfx, "_m_last"},  int'(m_last), 0);
        chk({pfx, "_done"},    int'(done), 0);
        chk({pfx, "_x_out"},   int'(x_out), 0);
        chk({pfx, "_m_index"}, int'(m_index), 0);
        chk({pfx, "_table"},   int'(table_out), 0);
        chk({pfx, "_count"},   int'(count_out), 0);
    endtask

    // rmode: 0 = always ready, 1 = ready held low 3 cycles per item, 2 = random ready.
    task automatic run_scan(input logic [TW-1:0] fn, input int rmode, input bit mval,
                            input bit poke, input int abort_idx);
        int  exp_q[$];
        int  cyc, emit_len, last, wait_cnt, idx, ones, acc_cyc;
        bit  done_seen, prev_hold;
        int  prev_idx;
        ones = 0;
        last = -1;
        for (int k = 0; k < TW; k++) begin
            if ((fn[k] ^ mval) == 1'b1) begin
                exp_q.push_back(k);
                ones++;
                last = k;
            end
        end
        emit_len  = (last < 0) ? TW : last + 1;
        done_seen = 1'b0;
        prev_hold = 1'b0;
        prev_idx  = 0;
        wait_cnt  = 0;
        acc_cyc   = 0;
        idx       = -1;

        @(negedge clk);
        func    = fn;
`ifdef MAXTERM_EN
        mode    = mval;
`endif
        start   = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 2;
        chk("busy_rise", int'(busy), 1);

        while (!done_seen && cyc < 400) begin
            if (cyc >= 2 && cyc <= 1 + TW) chk("x_out_scan", int'(x_out), cyc - 2);
            if (poke) start = (cyc == 6 || cyc == 14);
            case (rmode)
                0: m_ready = 1'b1;
                1: begin
                    if (m_valid) begin
                        if (wait_cnt < 3) begin
                            m_ready = 1'b0;
                            wait_cnt++;
                        end else begin
                            m_ready  = 1'b1;
                            wait_cnt = 0;
                        end
                    end else begin
                        m_ready = 1'($urandom_range(0, 1));
                    end
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase

            if (prev_hold) begin
                chk("hold_valid", int'(m_valid), 1);
                chk("hold_index", int'(m_index), prev_idx);
            end
            if (m_valid) begin
                chk("m_last", int'(m_last), (exp_q.size() == 1) ? 1 : 0);
                if (m_ready) begin
                    prev_hold = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("extra_index", int'(m_index), -1);
                    end else begin
                        idx = exp_q.pop_front();
                        chk("m_index", int'(m_index), idx);
                        acc_cyc = cyc;
                    end
                    if (abort_idx >= 0 && idx == abort_idx) begin
                        @(negedge clk);
                        m_ready = 1'b0;
                        start   = 1'b0;
                        rst_n   = 1'b0;
                        #1;
                        chk_idle_zero("abort");
                        @(negedge clk);
                        rst_n = 1'b1;
                        @(negedge clk);
                        chk("abort_idle_busy", int'(busy), 0);
                        chk("abort_idle_x", int'(x_out), 0);
                        return;
                    end
                end else begin
                    prev_hold = 1'b1;
                    prev_idx  = int'(m_index);
                end
            end else begin
                chk("m_last_novalid", int'(m_last), 0);
            end

            if (done) begin
                done_seen = 1'b1;
                start     = 1'b0;
                if (rmode == 0) chk("done_cycle", cyc, 1 + TW + emit_len + 1);
                if (ones > 0) chk("done_after_last", cyc - acc_cyc, 1);
                chk("table_out", int'(table_out), int'(fn));
                chk("count_out", int'(count_out), ones);
                chk("all_emitted", exp_q.size(), 0);
                chk("busy_at_done", int'(busy), 1);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!done_seen) begin
            chk("timeout_done", 0, 1);
        end else begin
            @(negedge clk);
            chk("done_pulse", int'(done), 0);
            chk("busy_fall", int'(busy), 0);
            chk("table_hold", int'(table_out), int'(fn));
            chk("count_hold", int'(count_out), ones);
        end
        m_ready = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        func    = '0;
`ifdef MAXTERM_EN
        mode    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // f = a&(b|c): minterms 5,6,7
        run_scan(8'b1110_0000, 0, 1'b0, 1'b0, -1);
        // constant 0: nothing emitted, full-length emit walk
        run_scan(8'h00, 0, 1'b0, 1'b0, -1);
        // constant 1 under 3-cycle backpressure
        run_scan(8'hFF, 1, 1'b0, 1'b0, -1);
        // start pulses during SCAN and EMIT are ignored
        run_scan(8'b1110_0000, 0, 1'b0, 1'b1, -1);
        // reset during EMIT after index 5 accepted, then clean rescan
        run_scan(8'hFF, 0, 1'b0, 1'b0, 5);
        run_scan(8'b1110_0000, 0, 1'b0, 1'b0, -1);
`ifdef MAXTERM_EN
        run_scan(8'b1110_0000, 0, 1'b1, 1'b0, -1);
        run_scan(8'hFF, 0, 1'b1, 1'b0, -1);
`endif
        for (int i = 0; i < 8; i++) begin
            logic [TW-1:0] rf;
            rf = TW'($urandom);
`ifdef MAXTERM_EN
            run_scan(rf, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
`else
            run_scan(rf, 2, 1'b0, 1'($urandom_range(0, 1)), -1);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
